// File: rtl/l2_wb_req_unit.sv
// Writeback-request engine for one PMESH L2 slice.
// Accepts WB_REQ on msg3, checks it against a small directory/data array, commits matching
// writebacks, optionally answers with WB_ACK on msg2, and counts commits and drops.
module l2_wb_req_unit #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned TAG_W    = 26,
  parameter int unsigned SRC_W    = 6,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned CNT_W    = 16,
  parameter logic [7:0]  WB_TYPE  = 8'h0C,
  parameter logic [7:0]  ACK_TYPE = 8'h0D,
  parameter bit          ACK_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg3_valid,
  output logic              msg3_ready,
  input  logic [7:0]        msg3_type,
  input  logic [TAG_W-1:0]  msg3_tag,
  input  logic [SRC_W-1:0]  msg3_source,
  input  logic [DATA_W-1:0] msg3_data,
  output logic              msg2_valid,
  input  logic              msg2_ready,
  output logic [7:0]        msg2_type,
  output logic [TAG_W-1:0]  msg2_tag,
  output logic [SRC_W-1:0]  msg2_dest,
  input  logic              fill_valid,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [SRC_W-1:0]  fill_owner,
  input  logic [1:0]        fill_state,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [IDX_W-1:0]  dbg_index,
  output logic [TAG_W-1:0]  dbg_tag,
  output logic [1:0]        dbg_vd,
  output logic [1:0]        dbg_state,
  output logic [SRC_W-1:0]  dbg_owner,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic [CNT_W-1:0]  wb_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned Lines = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StLookup, StWrite, StAck} state_e;

  state_e state_q, state_d;

  // Request fields captured on the accept edge; msg3 is ignored afterwards.
  logic [7:0]        req_type_q, req_type_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [SRC_W-1:0]  req_src_q, req_src_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              hit_q, hit_d;

  // Line array.
  logic [1:0]        vd_q    [Lines];
  logic [1:0]        vd_d    [Lines];
  logic [TAG_W-1:0]  tag_q   [Lines];
  logic [TAG_W-1:0]  tag_d   [Lines];
  logic [1:0]        lstate_q[Lines];
  logic [1:0]        lstate_d[Lines];
  logic [SRC_W-1:0]  owner_q [Lines];
  logic [SRC_W-1:0]  owner_d [Lines];
  logic [DATA_W-1:0] data_q  [Lines];
  logic [DATA_W-1:0] data_d  [Lines];

  logic              msg2_valid_q, msg2_valid_d;
  logic [7:0]        msg2_type_q, msg2_type_d;
  logic [TAG_W-1:0]  msg2_tag_q, msg2_tag_d;
  logic [SRC_W-1:0]  msg2_dest_q, msg2_dest_d;
  logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  fill_idx;

  assign req_idx  = req_tag_q[IDX_W-1:0];
  assign fill_idx = fill_tag[IDX_W-1:0];

  // Next-state: FSM sequencing, fill/commit array updates, ack and counters.
  always_comb begin
    state_d      = state_q;
    req_type_d   = req_type_q;
    req_tag_d    = req_tag_q;
    req_src_d    = req_src_q;
    req_data_d   = req_data_q;
    hit_d        = hit_q;
    vd_d         = vd_q;
    tag_d        = tag_q;
    lstate_d     = lstate_q;
    owner_d      = owner_q;
    data_d       = data_q;
    msg2_valid_d = msg2_valid_q;
    msg2_type_d  = msg2_type_q;
    msg2_tag_d   = msg2_tag_q;
    msg2_dest_d  = msg2_dest_q;
    wb_cnt_d     = wb_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    case (state_q)
      StIdle: begin
        // Fill wins over a simultaneous request; the request waits a cycle.
        if (fill_valid) begin
          vd_d[fill_idx]     = 2'b10;
          tag_d[fill_idx]    = fill_tag;
          lstate_d[fill_idx] = fill_state;
          owner_d[fill_idx]  = fill_owner;
          data_d[fill_idx]   = fill_data;
        end else if (msg3_valid) begin
          req_type_d = msg3_type;
          req_tag_d  = msg3_tag;
          req_src_d  = msg3_source;
          req_data_d = msg3_data;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        hit_d   = vd_q[req_idx][1] && (tag_q[req_idx] == req_tag_q) &&
                  (owner_q[req_idx] == req_src_q) && (req_type_q == WB_TYPE);
        state_d = StWrite;
      end
      StWrite: begin
        if (hit_q) begin
          data_d[req_idx]   = req_data_q;
          vd_d[req_idx]     = 2'b11;
          lstate_d[req_idx] = 2'b00;
          if (wb_cnt_q != CntMax) wb_cnt_d = wb_cnt_q + CNT_W'(1);
          if (ACK_EN) begin
            msg2_valid_d = 1'b1;
            msg2_type_d  = ACK_TYPE;
            msg2_tag_d   = req_tag_q;
            msg2_dest_d  = req_src_q;
            state_d      = StAck;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (drop_cnt_q != CntMax) drop_cnt_d = drop_cnt_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      StAck: begin
        if (msg2_ready) begin
          msg2_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset clears the array and abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      req_type_q   <= '0;
      req_tag_q    <= '0;
      req_src_q    <= '0;
      req_data_q   <= '0;
      hit_q        <= 1'b0;
      msg2_valid_q <= 1'b0;
      msg2_type_q  <= '0;
      msg2_tag_q   <= '0;
      msg2_dest_q  <= '0;
      wb_cnt_q     <= '0;
      drop_cnt_q   <= '0;
      for (int i = 0; i < Lines; i++) begin
        vd_q[i]     <= '0;
        tag_q[i]    <= '0;
        lstate_q[i] <= '0;
        owner_q[i]  <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_type_q   <= req_type_d;
      req_tag_q    <= req_tag_d;
      req_src_q    <= req_src_d;
      req_data_q   <= req_data_d;
      hit_q        <= hit_d;
      msg2_valid_q <= msg2_valid_d;
      msg2_type_q  <= msg2_type_d;
      msg2_tag_q   <= msg2_tag_d;
      msg2_dest_q  <= msg2_dest_d;
      wb_cnt_q     <= wb_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      for (int i = 0; i < Lines; i++) begin
        vd_q[i]     <= vd_d[i];
        tag_q[i]    <= tag_d[i];
        lstate_q[i] <= lstate_d[i];
        owner_q[i]  <= owner_d[i];
        data_q[i]   <= data_d[i];
      end
    end
  end

  assign msg3_ready = (state_q == StIdle) && !fill_valid;
  assign busy       = (state_q != StIdle);
  assign msg2_valid = msg2_valid_q;
  assign msg2_type  = msg2_type_q;
  assign msg2_tag   = msg2_tag_q;
  assign msg2_dest  = msg2_dest_q;
  assign wb_cnt     = wb_cnt_q;
  assign drop_cnt   = drop_cnt_q;

  assign dbg_tag    = tag_q[dbg_index];
  assign dbg_vd     = vd_q[dbg_index];
  assign dbg_state  = lstate_q[dbg_index];
  assign dbg_owner  = owner_q[dbg_index];
  assign dbg_data   = data_q[dbg_index];

endmodule
